ysyx_25030085_lsu: RTL



---
 rtl/ysyx_25030085_lsu_pkg.sv | 62 ++++++
 rtl/ysyx_25030085_lsu_ext.sv | 27 ++
 rtl/ysyx_25030085_lsu.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ysyx_25030085_lsu_pkg.sv
// Shared LSU definitions: funct3 size codes, FSM states, byte-mask type.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ysyx_25030085_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

  typedef logic [3:0] wmask_t;

  // True for the five RV32I load/store size codes.
  function automatic logic f3_defined(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  // Low address bits that do not fit the access size.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Low address bits with the size-offending ones cleared.
  function automatic logic [1:0] align_lo(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  // Byte-enable pattern for lane 0, before shifting to the target lane.
  function automatic wmask_t base_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data trimmed to the access size so unused lanes drive zero.
  function automatic logic [31:0] size_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {24'h0, d[7:0]};
      2'b01:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_ext.sv
// Load lane extraction with sign/zero extension from funct3.
// Latency: combinational.
// Backpressure: none.
module ysyx_25030085_lsu_ext
  import ysyx_25030085_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: one outstanding access, IDLE->REQ->WAIT->RESP; optional
// misalignment rejection under YSYX_25030085_LSU_MISALIGN_CHECK_EN.
// Latency: 3 cycles request-to-done minimum (1 for rejected requests); backpressure:
// req_ready only in IDLE, mem_valid held stable until mem_ready, TIMEOUT-cycle watchdog.
module ysyx_25030085_lsu
  import ysyx_25030085_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output wmask_t      mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        done,
  output logic        err
);

  localparam int CW = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;

  lsu_state_e     state_q, state_d;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [31:0]    addr_q, wdata_q, rdata_q;
  logic [4:0]     rd_q;
  logic           err_q;
  logic [CW-1:0]  cnt_q;

  logic           accept, reject, timeout_hit, timeout_fire;
  logic [1:0]     off;
  logic [31:0]    ext_data;

  assign accept = req_valid && (state_q == S_IDLE);
  assign off    = addr_q[1:0];

`ifdef YSYX_25030085_LSU_MISALIGN_CHECK_EN
  assign reject = !f3_defined(req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign reject = !f3_defined(req_funct3);
`endif

  // The watchdog only bites when the current phase makes no progress; a handshake
  // or response landing on the last counted cycle still wins.
  assign timeout_hit  = cnt_q >= CW'(TIMEOUT - 1);
  assign timeout_fire = timeout_hit &&
                        (((state_q == S_REQ) && !mem_ready) ||
                         ((state_q == S_WAIT) && !mem_rsp_valid));

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = reject ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_ready)        state_d = S_WAIT;
        else if (timeout_hit) state_d = S_RESP;
      end
      S_WAIT: if (mem_rsp_valid || timeout_hit) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter, error flag and response data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= {req_addr[31:2], align_lo(req_funct3, req_addr[1:0])};
        wdata_q <= size_data(req_funct3, req_wdata);
        rd_q    <= req_rd;
        err_q   <= reject;
        cnt_q   <= '0;
      end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
        cnt_q <= cnt_q + CW'(1);
        if (timeout_fire) err_q <= 1'b1;
      end
      if ((state_q == S_WAIT) && mem_rsp_valid) rdata_q <= mem_rdata;
    end
  end

  ysyx_25030085_lsu_ext u_ext (
    .rdata_i  (rdata_q),
    .off_i    (off),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  // Outputs decoded from state and the captured request.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_valid = (state_q == S_REQ);
    done      = (state_q == S_RESP);
    err       = (state_q == S_RESP) && err_q;
    wb_valid  = (state_q == S_RESP) && !err_q && !we_q && (rd_q != 5'd0);
    mem_we    = we_q;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q << {off, 3'b000};
    mem_wmask = we_q ? wmask_t'(base_mask(f3_q) << off) : 4'b0000;
    wb_rd     = rd_q;
    wb_data   = ext_data;
  end

endmodule
